// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: groups the fetch port, the loader port and the shared
// EEPROM bus of the instruction-memory arbiter.
//   fetch : f_req, f_addr[12:0] -> f_rdata[31:0], f_valid
//   loader: l_req, l_we, l_addr[14:0], l_wdata[7:0] -> l_rdata[7:0], l_done
//   memory: mem_ce_n, mem_oe_n, mem_we_n[3:0], mem_addr[12:0], mem_wdata[7:0]
//           <- mem_rdata[31:0] (lanes {3,2,1,0}); busy status
// Modport slave is the arbiter side; master is the requester/memory side.
interface imem_arbiter_if;
    localparam int unsigned WADDR_W = 13;
    localparam int unsigned BADDR_W = 15;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned LANES   = 4;

    logic                 f_req;
    logic [WADDR_W-1:0]   f_addr;
    logic [WORD_W-1:0]    f_rdata;
    logic                 f_valid;

    logic                 l_req;
    logic                 l_we;
    logic [BADDR_W-1:0]   l_addr;
    logic [BYTE_W-1:0]    l_wdata;
    logic [BYTE_W-1:0]    l_rdata;
    logic                 l_done;

    logic                 mem_ce_n;
    logic                 mem_oe_n;
    logic [LANES-1:0]     mem_we_n;
    logic [WADDR_W-1:0]   mem_addr;
    logic [BYTE_W-1:0]    mem_wdata;
    logic [WORD_W-1:0]    mem_rdata;

    logic                 busy;

    modport slave (
        input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
        output f_rdata, f_valid, l_rdata, l_done,
               mem_ce_n, mem_oe_n, mem_we_n, mem_addr, mem_wdata, busy
    );

    modport master (
        output f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
        input  f_rdata, f_valid, l_rdata, l_done,
               mem_ce_n, mem_oe_n, mem_we_n, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares four byte-wide EEPROM chips (one 32-bit word) between
// the instruction fetch port and a byte-wide loader port. Round-robin grant
// when both request, fixed-length read and write timing, registered outputs.
// Ports: clk (rising edge), rst (async, active low), bus (imem_arbiter_if.slave).
// Parameters: RD_WAIT extra read cycles, WR_WAIT write-recovery cycles.
// Macro IMEM_WRITE_EN enables loader writes (LWR/LWAIT); without it every
// loader request is a read and the write strobes are tied inactive.
module imem_arbiter #(
    parameter int unsigned RD_WAIT = 3,
    parameter int unsigned WR_WAIT = 15
) (
    input logic           clk,
    input logic           rst,
    imem_arbiter_if.slave bus
);
    localparam int unsigned CNT_MAX = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int unsigned CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
`ifdef IMEM_WRITE_EN
    localparam int unsigned WR_LAST = (WR_WAIT > 0) ? WR_WAIT - 1 : 0;
`endif

    typedef enum logic [2:0] {IDLE, FRD, LRD, LWR, LWAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_l_q, last_l_d;   // 1: loader got the last grant
    logic [1:0]    lane_q, lane_d;
    logic [12:0]   addr_q, addr_d;
    logic [31:0]   f_rdata_q, f_rdata_d;
    logic          f_valid_q, f_valid_d;
    logic [7:0]    l_rdata_q, l_rdata_d;
    logic          l_done_q, l_done_d;
    logic          ce_n_q, ce_n_d;
    logic          oe_n_q, oe_n_d;
    logic          grant_ok;
`ifdef IMEM_WRITE_EN
    logic [3:0]    we_n_q, we_n_d;
    logic [7:0]    wdata_q, wdata_d;
`endif

    // Next state, completion capture, grant and strobe generation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_l_d  = last_l_q;
        lane_d    = lane_q;
        addr_d    = addr_q;
        f_rdata_d = f_rdata_q;
        f_valid_d = 1'b0;
        l_rdata_d = l_rdata_q;
        l_done_d  = 1'b0;
        grant_ok  = 1'b0;
`ifdef IMEM_WRITE_EN
        wdata_d   = wdata_q;
`endif

        case (state_q)
            IDLE: grant_ok = 1'b1;
            FRD: begin
                if (cnt_q == CW'(RD_WAIT)) begin
                    f_rdata_d = bus.mem_rdata;
                    f_valid_d = 1'b1;
                    grant_ok  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LRD: begin
                if (cnt_q == CW'(RD_WAIT)) begin
                    l_rdata_d = bus.mem_rdata[{lane_q, 3'b000} +: 8];
                    l_done_d  = 1'b1;
                    grant_ok  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef IMEM_WRITE_EN
            // Write pulse is two cycles long
            LWR: begin
                if (cnt_q == CW'(1)) begin
                    if (WR_WAIT == 0) begin
                        l_done_d = 1'b1;
                        grant_ok = 1'b1;
                    end else begin
                        state_d = LWAIT;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LWAIT: begin
                if (cnt_q == CW'(WR_LAST)) begin
                    l_done_d = 1'b1;
                    grant_ok = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Idle and completing cycles may grant; fetch wins a tie unless it went last
        if (grant_ok) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (bus.f_req && (!bus.l_req || last_l_q)) begin
                state_d  = FRD;
                addr_d   = bus.f_addr;
                last_l_d = 1'b0;
            end else if (bus.l_req) begin
`ifdef IMEM_WRITE_EN
                state_d  = bus.l_we ? LWR : LRD;
                wdata_d  = bus.l_wdata;
`else
                state_d  = LRD;
`endif
                addr_d   = bus.l_addr[14:2];
                lane_d   = bus.l_addr[1:0];
                last_l_d = 1'b1;
            end
        end

        ce_n_d = 1'b1;
        oe_n_d = 1'b1;
`ifdef IMEM_WRITE_EN
        we_n_d = 4'hF;
`endif
        case (state_d)
            FRD, LRD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
            end
`ifdef IMEM_WRITE_EN
            LWR: begin
                ce_n_d         = 1'b0;
                we_n_d[lane_d] = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_l_q  <= 1'b1;
            lane_q    <= 2'b00;
            addr_q    <= '0;
            f_rdata_q <= '0;
            f_valid_q <= 1'b0;
            l_rdata_q <= '0;
            l_done_q  <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
`ifdef IMEM_WRITE_EN
            we_n_q    <= 4'hF;
            wdata_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_l_q  <= last_l_d;
            lane_q    <= lane_d;
            addr_q    <= addr_d;
            f_rdata_q <= f_rdata_d;
            f_valid_q <= f_valid_d;
            l_rdata_q <= l_rdata_d;
            l_done_q  <= l_done_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
`ifdef IMEM_WRITE_EN
            we_n_q    <= we_n_d;
            wdata_q   <= wdata_d;
`endif
        end
    end

    assign bus.f_rdata  = f_rdata_q;
    assign bus.f_valid  = f_valid_q;
    assign bus.l_rdata  = l_rdata_q;
    assign bus.l_done   = l_done_q;
    assign bus.mem_ce_n = ce_n_q;
    assign bus.mem_oe_n = oe_n_q;
    assign bus.mem_addr = addr_q;
    assign bus.busy     = (state_q != IDLE);
`ifdef IMEM_WRITE_EN
    assign bus.mem_we_n  = we_n_q;
    assign bus.mem_wdata = wdata_q;
`else
    assign bus.mem_we_n  = 4'hF;
    assign bus.mem_wdata = 8'h00;
    // Write-side inputs have no function in a read-only build
    logic unused_c;
    assign unused_c = ^{bus.l_we, bus.l_wdata};
`endif
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: randomized traffic against a transaction-timeline model of
// the arbiter, plus directed scenarios with hand-computed expectations.
module tb_imem_arbiter;
    localparam int unsigned RD_WAIT = 3;
    localparam int unsigned WR_WAIT = 15;
`ifdef IMEM_WRITE_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   chk_en = 1'b0;

    imem_arbiter_if bus();

    imem_arbiter #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model: one transaction with a timeline ----
    int         m_cyc;
    bit         m_act;
    int         m_kind;      // 0 fetch, 1 loader read, 2 loader write
    int         m_grant, m_done;
    logic [1:0] m_lane;
    bit         m_last_l;
    logic [31:0] e_f_rdata;
    logic        e_f_valid;
    logic [7:0]  e_l_rdata;
    logic        e_l_done;
    logic [12:0] e_addr;
    logic [7:0]  e_wdata;
    logic        e_ce_n, e_oe_n, e_busy;
    logic [3:0]  e_we_n;

    task automatic model_reset();
        m_cyc = 0; m_act = 0; m_kind = 0; m_grant = 0; m_done = 0; m_lane = 0;
        m_last_l = 1;
        e_f_rdata = 0; e_f_valid = 0; e_l_rdata = 0; e_l_done = 0;
        e_addr = 0; e_wdata = 0; e_ce_n = 1; e_oe_n = 1; e_we_n = 4'hF; e_busy = 0;
    endtask

    task automatic model_step();
        int off;
        m_cyc++;
        e_f_valid = 0;
        e_l_done  = 0;
        if (m_act && m_cyc == m_done) begin
            if (m_kind == 0) begin
                e_f_rdata = bus.mem_rdata;
                e_f_valid = 1;
            end else begin
                if (m_kind == 1) e_l_rdata = bus.mem_rdata[8*m_lane +: 8];
                e_l_done = 1;
            end
            m_act = 0;
        end
        if (!m_act && (bus.f_req || bus.l_req)) begin
            m_act   = 1;
            m_grant = m_cyc;
            if (bus.f_req && (!bus.l_req || m_last_l)) begin
                m_kind   = 0;
                e_addr   = bus.f_addr;
                m_last_l = 0;
            end else begin
                m_kind   = (WR_EN && bus.l_we) ? 2 : 1;
                e_addr   = bus.l_addr[14:2];
                m_lane   = bus.l_addr[1:0];
                if (WR_EN) e_wdata = bus.l_wdata;
                m_last_l = 1;
            end
            m_done = m_cyc + ((m_kind == 2) ? int'(2 + WR_WAIT) : int'(RD_WAIT + 1));
        end
        e_ce_n = 1; e_oe_n = 1; e_we_n = 4'hF;
        if (m_act) begin
            off = m_cyc - m_grant;
            if (m_kind != 2) begin
                e_ce_n = 0; e_oe_n = 0;
            end else if (off < 2) begin
                e_ce_n = 0;
                e_we_n[m_lane] = 1'b0;
            end
        end
        e_busy = m_act;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_step();
        end
    end

    // Compare process: outputs checked mid-cycle against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("f_valid", 32'(bus.f_valid), 32'(e_f_valid));
                check("l_done",  32'(bus.l_done),  32'(e_l_done));
                check("f_rdata", bus.f_rdata, e_f_rdata);
                check("l_rdata", 32'(bus.l_rdata), 32'(e_l_rdata));
                check("ce_n",    32'(bus.mem_ce_n), 32'(e_ce_n));
                check("oe_n",    32'(bus.mem_oe_n), 32'(e_oe_n));
                check("we_n",    32'(bus.mem_we_n), 32'(e_we_n));
                check("busy",    32'(bus.busy), 32'(e_busy));
                if (e_busy) check("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
                if (e_we_n != 4'hF || !WR_EN) check("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic clear_inputs();
        bus.f_req = 0; bus.f_addr = 0; bus.l_req = 0; bus.l_we = 0;
        bus.l_addr = 0; bus.l_wdata = 0; bus.mem_rdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    task automatic wait_idle(string name);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.busy) begin ok = 1; break; end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    initial begin
        int lat, oe_cnt, nv, f_k, l_k, we_cnt, bad_we;
        int vk[3];
        logic [7:0] wd_seen;

        clear_inputs();
        rst = 0;
        repeat (2) @(negedge clk);
        check("rst_ce_n",    32'(bus.mem_ce_n), 32'd1);
        check("rst_oe_n",    32'(bus.mem_oe_n), 32'd1);
        check("rst_we_n",    32'(bus.mem_we_n), 32'hF);
        check("rst_busy",    32'(bus.busy), 32'd0);
        check("rst_f_valid", 32'(bus.f_valid), 32'd0);
        check("rst_l_done",  32'(bus.l_done), 32'd0);
        check("rst_f_rdata", bus.f_rdata, 32'd0);
        check("rst_l_rdata", 32'(bus.l_rdata), 32'd0);
        check("rst_addr",    32'(bus.mem_addr), 32'd0);
        check("rst_wdata",   32'(bus.mem_wdata), 32'd0);
        rst = 1;
        chk_en = 1;

        // Single fetch: latency, data and oe width
        bus.mem_rdata = 32'h00500093; bus.f_addr = 13'h0004; bus.f_req = 1;
        lat = -1; oe_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) check("fetch_addr", 32'(bus.mem_addr), 32'h4);
            if (bus.f_valid) begin lat = k - 1; break; end
            if (!bus.mem_oe_n) oe_cnt++;
        end
        bus.f_req = 0;
        check("fetch_latency", 32'(lat), 32'd4);
        check("fetch_rdata", bus.f_rdata, 32'h00500093);
        check("fetch_oe_cycles", 32'(oe_cnt), 32'd4);
        wait_idle("idle_after_fetch");

        // Held fetch: three back-to-back completions every 4 cycles
        bus.f_req = 1; nv = 0;
        for (int k = 1; k <= 40 && nv < 3; k++) begin
            @(negedge clk);
            if (bus.f_valid) begin vk[nv] = k; nv++; end
        end
        bus.f_req = 0;
        check("b2b_count", 32'(nv), 32'd3);
        check("b2b_first", 32'(vk[0] - 1), 32'd4);
        check("b2b_gap1", 32'(vk[1] - vk[0]), 32'd4);
        check("b2b_gap2", 32'(vk[2] - vk[1]), 32'd4);
        wait_idle("idle_after_b2b");

        // Contested first grant: fetch, then loader
        do_reset();
        bus.mem_rdata = 32'hDEADBEEF;
        bus.f_req = 1; bus.l_req = 1; bus.l_we = 0; bus.l_addr = 15'h0012;
        f_k = -1; l_k = -1;
        for (int k = 1; k <= 40 && (f_k < 0 || l_k < 0); k++) begin
            @(negedge clk);
            if (bus.f_valid && f_k < 0) begin f_k = k; bus.f_req = 0; end
            if (bus.l_done && l_k < 0)  begin l_k = k; bus.l_req = 0; end
        end
        check("rr_fetch_first", 32'(f_k), 32'd5);
        check("rr_loader_second", 32'(l_k), 32'd9);
        check("rr_l_rdata", 32'(bus.l_rdata), 32'hAD);
        wait_idle("idle_after_rr");

        // Loader write (read when writes are compiled out); request dropped after grant
        do_reset();
        bus.l_req = 1; bus.l_we = 1; bus.l_addr = 15'h0007; bus.l_wdata = 8'hA5;
        lat = -1; we_cnt = 0; bad_we = 0; wd_seen = 8'h00;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.l_req = 0;
            if (bus.mem_we_n == 4'b0111) begin we_cnt++; wd_seen = bus.mem_wdata; end
            else if (bus.mem_we_n != 4'hF) bad_we++;
            if (bus.l_done) begin lat = k - 1; break; end
        end
        check("wr_latency", 32'(lat), WR_EN ? 32'd17 : 32'd4);
        check("wr_we_cycles", 32'(we_cnt), WR_EN ? 32'd2 : 32'd0);
        check("wr_bad_we", 32'(bad_we), 32'd0);
        check("wr_wdata", 32'(wd_seen), WR_EN ? 32'hA5 : 32'h00);
        wait_idle("idle_after_wr");

        // Reset during the second write-pulse cycle
        do_reset();
        bus.l_req = 1; bus.l_we = 1; bus.l_addr = 15'h0007; bus.l_wdata = 8'hA5;
        @(negedge clk);
        bus.l_req = 0;
        @(posedge clk);
        #2 rst = 0;
        #1;
        check("mid_rst_ce_n", 32'(bus.mem_ce_n), 32'd1);
        check("mid_rst_oe_n", 32'(bus.mem_oe_n), 32'd1);
        check("mid_rst_we_n", 32'(bus.mem_we_n), 32'hF);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1;
        nv = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.l_done || bus.busy) nv++;
        end
        check("mid_rst_no_done", 32'(nv), 32'd0);

        // Randomized traffic from both requesters
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            bus.mem_rdata = $urandom;
            if (bus.f_req) begin
                if (bus.f_valid) begin
                    if ($urandom_range(3) == 0) bus.f_req = 0;
                    else bus.f_addr = 13'($urandom);
                end else if ($urandom_range(31) == 0) bus.f_req = 0;
                else if ($urandom_range(7) == 0) bus.f_addr = 13'($urandom);
            end else if ($urandom_range(2) == 0) begin
                bus.f_req = 1; bus.f_addr = 13'($urandom);
            end
            if (bus.l_req) begin
                if (bus.l_done) begin
                    if ($urandom_range(1) == 0) bus.l_req = 0;
                    else begin
                        bus.l_we = 1'($urandom); bus.l_addr = 15'($urandom); bus.l_wdata = 8'($urandom);
                    end
                end else if ($urandom_range(39) == 0) bus.l_req = 0;
            end else if ($urandom_range(3) == 0) begin
                bus.l_req = 1; bus.l_we = 1'($urandom);
                bus.l_addr = 15'($urandom); bus.l_wdata = 8'($urandom);
            end
        end
        bus.f_req = 0; bus.l_req = 0;
        wait_idle("idle_after_random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter RD_WAIT, default 3: extra EEPROM read-access cycles beyond the first.
REQ-002 SHALL have parameter WR_WAIT, default 15: write-recovery cycles after a write pulse.
REQ-003 SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port f_req  input  1  fetch read request, held until f_valid.
REQ-006 SHALL have port f_addr  input  13  fetch word address (pc[14:2]).
REQ-007 SHALL have port f_rdata  output  32  registered fetch instruction word.
REQ-008 SHALL have port f_valid  output  1  one-cycle fetch-complete pulse.
REQ-009 SHALL have port l_req  input  1  loader request, held until l_done.
REQ-010 SHALL have port l_we  input  1  loader write (1) or read (0).
REQ-011 SHALL have port l_addr  input  15  loader byte address; [1:0] selects chip lane.
REQ-012 SHALL have port l_wdata  input  8  loader write byte.
REQ-013 SHALL have port l_rdata  output  8  registered loader read byte.
REQ-014 SHALL have port l_done  output  1  one-cycle loader-complete pulse.
REQ-015 SHALL have ports mem_ce_n, mem_oe_n  output  1 each  active-low chip-enable and output-enable, shared by all four chips.
REQ-016 SHALL have port mem_we_n  output  4  per-lane active-low write enable.
REQ-017 SHALL have ports mem_addr  output  13  word address; mem_wdata  output  8  broadcast write byte; mem_rdata  input  32  lanes {3,2,1,0}.
REQ-018 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-019 SHALL implement states IDLE, FRD, LRD, LWR, LWAIT.
REQ-020 In IDLE, one request SHALL be granted per rising edge: f_req alone -> FRD; l_req alone -> LRD (l_we=0) or LWR (l_we=1).
REQ-021 With f_req and l_req both high in IDLE, grant SHALL be round-robin against a last-grant flag; flag updates on every grant.
REQ-022 Granted address/data SHALL be latched at the grant edge; mem_addr = f_addr or l_addr[14:2]; later requester changes are ignored until completion.
REQ-023 FRD/LRD SHALL assert mem_ce_n=0, mem_oe_n=0 for exactly RD_WAIT+1 cycles, then capture mem_rdata and return to IDLE.
REQ-024 Fetch latency: f_req sampled at edge E -> f_rdata updated and f_valid=1 for the cycle following edge E+RD_WAIT+1.
REQ-025 LRD SHALL load l_rdata with lane l_addr[1:0] of mem_rdata and pulse l_done with the same timing as REQ-024.
REQ-026 LWR SHALL drive mem_ce_n=0, mem_oe_n=1, mem_wdata=l_wdata and the lane-selected mem_we_n bit low for 2 cycles; other lanes stay high.
REQ-027 LWAIT SHALL hold all strobes inactive for WR_WAIT cycles, then pulse l_done and return to IDLE.
REQ-028 The completing cycle SHALL allow a new grant (back-to-back), so a held f_req restarts FRD on the edge f_valid rises.
REQ-029 A request dropped mid-access SHALL NOT abort it; the completion pulse still fires.
REQ-030 f_valid and l_done SHALL never be high in the same cycle; f_rdata/l_rdata SHALL hold until the next capture.
REQ-031 Outside FRD/LRD/LWR, mem_ce_n, mem_oe_n and all mem_we_n bits SHALL be 1.

Reset
REQ-032 rst=0 SHALL immediately force state IDLE, mem_ce_n=mem_oe_n=1, mem_we_n=4'hF, busy=0, f_valid=l_done=0, f_rdata=0, l_rdata=0, mem_addr=0, mem_wdata=0, counter=0.
REQ-033 Reset SHALL set last-grant to loader, so fetch wins the first contested grant.
REQ-034 Reset asserted mid-write SHALL cut the we pulse at once; the interrupted operation SHALL NOT signal completion.

Configuration
REQ-035 With macro IMEM_WRITE_EN defined, LWR/LWAIT SHALL exist as specified.
REQ-036 Without IMEM_WRITE_EN, l_we SHALL be ignored (loader requests are reads), mem_we_n SHALL be tied to 4'hF, mem_wdata to 0, and LWR/LWAIT SHALL not be synthesized.

Verification
REQ-037 Reset, f_req=1, f_addr=13'h0004, mem_rdata=32'h00500093 -> f_valid 4 cycles after sampling edge, f_rdata=32'h00500093, oe_n low exactly 4 cycles.
REQ-038 f_req held high 3 accesses -> f_valid every 4 cycles, no idle gap.
REQ-039 f_req and l_req (read, l_addr=15'h0012) rise together after reset -> fetch first, then loader; l_rdata = mem_rdata[23:16].
REQ-040 IMEM_WRITE_EN, l_we=1, l_addr=15'h0007, l_wdata=8'hA5 -> mem_we_n=4'b0111 for 2 cycles, mem_wdata=8'hA5, l_done 17 cycles after grant edge.
REQ-041 Without IMEM_WRITE_EN, same stimulus -> mem_we_n stays 4'hF, treated as read, l_done after 4 cycles.
REQ-042 rst=0 in second LWR cycle -> all strobes inactive asynchronously, no l_done, state IDLE after release.
